// File: rtl/decimal_key_encoder.sv
`default_nettype none
// ============================================================================
// Module   : decimal_key_encoder
// Brief    : Debounced one-hot decimal keypad to 4-bit binary encoder with a
//            valid/ready output. Optional macro DEC_ENC_ERR_EN rejects
//            multi-key presses with an err pulse instead of priority-encoding.
// Revision : 1.0 - initial release
// ============================================================================
module decimal_key_encoder #(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] dec_in,
    input  logic       bin_ready,
    output logic [3:0] bin_out,
    output logic       bin_valid,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DEB     = 2'd1,
        S_SEND    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [7:0] c_deb_last = 8'(DEB_CYCLES - 1);

    logic [9:0] r_sync1;
    logic [9:0] r_sync2;
    logic [9:0] w_ds;
    state_t     r_state;
    state_t     w_state_nxt;
    logic [9:0] r_sample;
    logic [9:0] w_sample_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [3:0] r_bin_out;
    logic [3:0] w_bin_out_nxt;
    logic       r_bin_valid;
    logic       w_bin_valid_nxt;
    logic [3:0] w_hi_idx;
    logic       w_reject;

    assign w_ds = r_sync2;

    // Highest set bit wins when several keys are down together.
    always_comb begin
        w_hi_idx = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (r_sample[k]) begin
                w_hi_idx = 4'(k);
            end
        end
    end

`ifdef DEC_ENC_ERR_EN
    logic w_multi;
    logic r_err;

    assign w_multi  = (r_sample & (r_sample - 10'd1)) != 10'd0;
    assign w_reject = w_multi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (r_state == S_DEB) && (w_ds == r_sample) &&
                     (r_cnt == c_deb_last) && w_multi;
        end
    end

    assign err = r_err;
`else
    assign w_reject = 1'b0;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1     <= 10'd0;
            r_sync2     <= 10'd0;
            r_state     <= S_IDLE;
            r_sample    <= 10'd0;
            r_cnt       <= 8'd0;
            r_bin_out   <= 4'd0;
            r_bin_valid <= 1'b0;
        end else begin
            r_sync1     <= dec_in;
            r_sync2     <= r_sync1;
            r_state     <= w_state_nxt;
            r_sample    <= w_sample_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bin_out   <= w_bin_out_nxt;
            r_bin_valid <= w_bin_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sample_nxt    = r_sample;
        w_cnt_nxt       = r_cnt;
        w_bin_out_nxt   = r_bin_out;
        w_bin_valid_nxt = r_bin_valid;
        case (r_state)
            S_IDLE: begin
                if (w_ds != 10'd0) begin
                    w_sample_nxt = w_ds;
                    w_cnt_nxt    = 8'd0;
                    w_state_nxt  = S_DEB;
                end
            end
            S_DEB: begin
                if (w_ds == 10'd0) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_IDLE;
                end else if (w_ds != r_sample) begin
                    w_sample_nxt = w_ds;
                    w_cnt_nxt    = 8'd0;
                end else if (r_cnt != c_deb_last) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end else if (w_reject) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_RELEASE;
                end else begin
                    w_bin_out_nxt   = w_hi_idx;
                    w_bin_valid_nxt = 1'b1;
                    w_state_nxt     = S_SEND;
                end
            end
            S_SEND: begin
                if (bin_ready) begin
                    w_bin_valid_nxt = 1'b0;
                    w_cnt_nxt       = 8'd0;
                    w_state_nxt     = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // Any key activity restarts the release window; no auto-repeat.
                if (w_ds != 10'd0) begin
                    w_cnt_nxt = 8'd0;
                end else if (r_cnt == c_deb_last) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bin_out   = r_bin_out;
    assign bin_valid = r_bin_valid;

endmodule
`default_nettype wire

// File: tb/tb_decimal_key_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_decimal_key_encoder
// Brief    : Self-checking bench for decimal_key_encoder (directed + random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_decimal_key_encoder;

    localparam int DEB_CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] dec_in;
    logic       bin_ready;
    logic [3:0] bin_out;
    logic       bin_valid;
    logic       err;

    int total = 0;
    int bad   = 0;

    int          n_xfer = 0;
    int          n_err  = 0;
    logic [3:0]  got_q[$];
    logic        hold_prev = 1'b0;
    logic        xfer_prev = 1'b0;
    logic [3:0]  out_prev  = 4'd0;

    decimal_key_encoder #(
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dec_in    (dec_in),
        .bin_ready (bin_ready),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic release_idle();
        dec_in    = 10'd0;
        bin_ready = 1'b1;
        tick(DEB_CYCLES + 6);
    endtask

    // Handshake observer: logs transfers and err pulses, checks hold/drop rules.
    always @(negedge clk) begin
        if (rst) begin
            hold_prev <= 1'b0;
            xfer_prev <= 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", 32'(bin_valid), 32'd1);
                check("hold_out", 32'(bin_out), 32'(out_prev));
            end
            if (xfer_prev) begin
                check("valid_drop", 32'(bin_valid), 32'd0);
            end
            hold_prev <= bin_valid && !bin_ready;
            xfer_prev <= bin_valid && bin_ready;
            out_prev  <= bin_out;
            if (bin_valid && bin_ready) begin
                n_xfer <= n_xfer + 1;
                got_q.push_back(bin_out);
            end
            if (err) begin
                n_err <= n_err + 1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0, e0, waited, hi, exp_err;
        logic [9:0] v;

        rst = 1'b1; dec_in = 10'd0; bin_ready = 1'b0;
        tick(3);
        check("rst_valid", 32'(bin_valid), 32'd0);
        check("rst_out", 32'(bin_out), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick(2);
        check("post_rst_valid", 32'(bin_valid), 32'd0);

        // Press 5: valid is a one-cycle pulse exactly DEB_CYCLES+3 cycles later.
        x0 = n_xfer;
        bin_ready = 1'b1;
        dec_in = 10'b00_0010_0000;
        for (int i = 1; i <= 9; i++) begin
            tick(1);
            check("t1_valid", 32'(bin_valid), 32'(i == DEB_CYCLES + 3));
            if (i >= DEB_CYCLES + 3) check("t1_out", 32'(bin_out), 32'd5);
        end
        check("t1_count", 32'(n_xfer - x0), 32'd1);
        release_idle();

        // Press 9 with consumer stalled, then exactly one transfer while held.
        x0 = n_xfer;
        bin_ready = 1'b0;
        dec_in = 10'h200;
        for (int i = 1; i <= 27; i++) begin
            tick(1);
            check("t2_valid", 32'(bin_valid), 32'(i >= DEB_CYCLES + 3));
            if (i >= DEB_CYCLES + 3) check("t2_out", 32'(bin_out), 32'd9);
        end
        bin_ready = 1'b1;
        tick(1);
        check("t2_drop", 32'(bin_valid), 32'd0);
        tick(30);
        check("t2_count", 32'(n_xfer - x0), 32'd1);
        if (got_q.size() > 0) check("t2_digit", 32'(got_q[$]), 32'd9);
        release_idle();

        // Glitch on 3 must not produce a digit; stable 7 must.
        x0 = n_xfer;
        dec_in = 10'h008; tick(2);
        dec_in = 10'h000; tick(1);
        dec_in = 10'h080; tick(15);
        check("t3_count", 32'(n_xfer - x0), 32'd1);
        if (got_q.size() > 0) check("t3_digit", 32'(got_q[$]), 32'd7);
        release_idle();

        // Two keys (0 and 3) together.
        x0 = n_xfer; e0 = n_err;
        dec_in = 10'b00_0000_1001; tick(15);
`ifdef DEC_ENC_ERR_EN
        check("t4_err", 32'(n_err - e0), 32'd1);
        check("t4_noxfer", 32'(n_xfer - x0), 32'd0);
        check("t4_out_kept", 32'(bin_out), 32'd7);
`else
        check("t4_count", 32'(n_xfer - x0), 32'd1);
        if (got_q.size() > 0) check("t4_digit", 32'(got_q[$]), 32'd3);
        check("t4_noerr", 32'(n_err - e0), 32'd0);
`endif
        release_idle();

        // Bouncy releases: short zero runs never re-arm; a clean run does.
        x0 = n_xfer;
        dec_in = 10'h004; tick(12);
        dec_in = 10'h000; tick(2);
        dec_in = 10'h004; tick(1);
        dec_in = 10'h000; tick(3);
        dec_in = 10'h004; tick(15);
        check("t5_short_release", 32'(n_xfer - x0), 32'd1);
        dec_in = 10'h000; tick(2);
        dec_in = 10'h004; tick(1);
        dec_in = 10'h000; tick(10);
        dec_in = 10'h004; tick(15);
        check("t5_count", 32'(n_xfer - x0), 32'd2);
        if (got_q.size() > 1) begin
            check("t5_digit_a", 32'(got_q[got_q.size() - 2]), 32'd2);
            check("t5_digit_b", 32'(got_q[$]), 32'd2);
        end
        release_idle();

        // Asynchronous reset while a digit is pending.
        bin_ready = 1'b0;
        dec_in = 10'h010; tick(8);
        check("t6_pre_valid", 32'(bin_valid), 32'd1);
        check("t6_pre_out", 32'(bin_out), 32'd4);
        #2 rst = 1'b1;
        #1;
        check("t6_async_valid", 32'(bin_valid), 32'd0);
        check("t6_async_out", 32'(bin_out), 32'd0);
        dec_in = 10'd0;
        tick(2);
        rst = 1'b0;
        x0 = n_xfer;
        bin_ready = 1'b1;
        dec_in = 10'h040; tick(12);
        check("t6_count", 32'(n_xfer - x0), 32'd1);
        if (got_q.size() > 0) check("t6_digit", 32'(got_q[$]), 32'd6);
        release_idle();

        // Random presses with optional glitches, multi-key and random ready.
        for (int it = 0; it < 24; it++) begin
            v = 10'd1 << $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) v = v | (10'd1 << $urandom_range(0, 9));
            hi = 0;
            for (int k = 0; k < 10; k++) if (v[k]) hi = k;
`ifdef DEC_ENC_ERR_EN
            exp_err = ($countones(v) > 1) ? 1 : 0;
`else
            exp_err = 0;
`endif
            if ($urandom_range(0, 1) == 1) begin
                dec_in = 10'd1 << $urandom_range(0, 9);
                tick($urandom_range(1, DEB_CYCLES));
                dec_in = 10'd0;
                tick(1);
            end
            x0 = n_xfer; e0 = n_err;
            dec_in = v;
            repeat ($urandom_range(DEB_CYCLES + 4, DEB_CYCLES + 12)) begin
                bin_ready = 1'($urandom_range(0, 1));
                tick(1);
            end
            dec_in = 10'd0;
            waited = 0;
            while (n_xfer == x0 && n_err == e0 && waited < 100) begin
                bin_ready = 1'($urandom_range(0, 1));
                tick(1);
                waited++;
            end
            bin_ready = 1'b1;
            tick(DEB_CYCLES + 6);
            check("rnd_event", 32'((n_xfer - x0) + (n_err - e0)), 32'd1);
            check("rnd_err", 32'(n_err - e0), 32'(exp_err));
            if (exp_err == 0 && n_xfer != x0 && got_q.size() > 0)
                check("rnd_digit", 32'(got_q[$]), 32'(hi));
        end

`ifndef DEC_ENC_ERR_EN
        check("err_never", 32'(n_err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decimal_key_encoder.md
# decimal_key_encoder

Sequential counterpart of the 4-bit binary-to-decimal line decoder: converts ten one-hot decimal key lines (digits 0–9) back into a 4-bit binary code. Inputs are debounced, encoded, and delivered as one binary digit per key press over a valid/ready handshake. The block sits between a decimal keypad or switch bank and downstream binary logic (counters, ALU operand registers, display drivers).

## Interface
- `DEB_CYCLES`, default 4: consecutive stable cycles required to accept a press or a release. Legal range 1–255.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `dec_in`  in  10  decimal key lines; bit k high means digit k is pressed. Asynchronous to `clk`; the block adds a 2-flop synchronizer.
- `bin_ready`  in  1  consumer accepts `bin_out` on this cycle.
- `bin_out`  out  4  encoded digit, 0–9.
- `bin_valid`  out  1  `bin_out` holds a new digit.
- `err`  out  1  one-cycle pulse for a rejected multi-key press. Tied to 0 when `DEC_ENC_ERR_EN` is undefined.

## Operation
- `dec_in` passes through a 2-flop synchronizer; `ds` is the synchronized value. All rules below refer to `ds`.
- Internal state: `sample` (10 b) and an 8-bit counter `cnt`.
- FSM states: IDLE, DEB, SEND, RELEASE.
- **IDLE**
  - If `ds != 0`: `sample <= ds`, `cnt <= 0`, go to DEB.
- **DEB**
  - `ds == sample` and `cnt == DEB_CYCLES-1`: debounce is complete; the encode step runs.
  - `ds == sample`, count not yet reached: `cnt++`.
  - `ds == 0`: go to IDLE with no output.
  - `ds` nonzero but different from `sample`: `sample <= ds`, `cnt <= 0`, stay in DEB.
- **Encode step**
  - Single hot bit k: `bin_out <= k`, `bin_valid <= 1`, go to SEND.
  - Multi-hot: see Configuration.
- **SEND**
  - `bin_valid` and `bin_out` are held stable until a cycle where `bin_ready` is 1.
  - On that edge: `bin_valid <= 0`, `cnt <= 0`, go to RELEASE.
  - Releasing the key during SEND does not cancel the pending digit.
- **RELEASE**
  - `ds == 0` for `DEB_CYCLES` consecutive cycles: go to IDLE.
  - Any nonzero `ds` during this wait clears `cnt`.
  - There is no auto-repeat: a held key yields exactly one digit.
- `bin_out` keeps its last value after the handshake; it changes only at the encode step.

## Timing
- Reset values: state IDLE, `bin_out` = 0, `bin_valid` = 0, `err` = 0, `cnt` = 0, `sample` = 0, synchronizer flops = 0.
- Reset is asynchronous in both directions: assertion during any state (including SEND with `bin_valid` high) clears all outputs immediately. There is no pending-digit recovery after reset.
- Press latency, with `dec_in` stable and k = `DEB_CYCLES`:
  - 2 edges through the synchronizer.
  - IDLE captures on the next edge, E0.
  - `bin_valid` rises after edge E0 + k.
  - Total: `bin_valid` is high k + 3 cycles after `dec_in` changes.
- Handshake: the transfer occurs on an edge where `bin_valid` and `bin_ready` are both 1. `bin_valid` is low the following cycle. `bin_ready` may be held high permanently.
- Minimum spacing between two presses: 1 handshake cycle + `DEB_CYCLES` release cycles + the press latency.
- `err` is a single-cycle pulse, registered, asserted the cycle after the encode edge.

## Configuration
- Macro `DEC_ENC_ERR_EN`.
- **Defined:** a multi-hot debounced `sample` does not produce a digit.
  - `err` pulses for 1 cycle and `bin_valid` stays 0.
  - `bin_out` is unchanged and the FSM goes to RELEASE.
- **Undefined:** a multi-hot `sample` is priority-encoded to its highest set bit and delivered normally; `err` is constant 0.

## Test plan
- Reset, then `dec_in` = 10'b00_0010_0000, `bin_ready` = 1, `DEB_CYCLES` = 4 → `bin_valid` is a single-cycle pulse 7 cycles after the input change; `bin_out` = 5 and stays 5 afterward.
- `dec_in` bit 9 held, `bin_ready` = 0 for 20 cycles, then 1 → `bin_valid` held with `bin_out` = 9 until `bin_ready` rises. Exactly one transfer while the key stays held.
- Glitch: bit 3 high for 2 cycles, low, then bit 7 stable → no digit for 3; exactly one digit, 7.
- `dec_in` = 10'b00_0000_1001 stable:
  - with `DEC_ENC_ERR_EN` → one `err` pulse, no `bin_valid`;
  - without it → `bin_out` = 3, `err` = 0.
- Key release bouncing: 0 for 2 cycles, bit 2 for 1 cycle, 0 stable, then bit 2 pressed again → exactly two digits, both 2. The second follows only after 4 clean release cycles.
- `rst` asserted mid-SEND with `bin_valid` = 1 → `bin_valid` and `bin_out` are 0 without waiting for a clock edge; after release, a new press encodes normally.
